// File: rtl/relu_maxpool_store.sv
// ReLU + 2x2 max-pool stage: pools Q4.13 result beats and streams pooled words into feature-map BRAM.
// Build option: define LENET_RELU_EN to clamp negative lanes to zero before pooling.
module relu_maxpool_store #(
  parameter int LANES     = 10,
  parameter int DW        = 17,
  parameter int ADDR_W    = 10,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4:0]                cfg_row_beats,
  input  logic [5:0]                cfg_out_rows,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic                      in_vld,
  input  logic [LANES*DW-1:0]       in_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [(LANES/2)*DW-1:0]   wr_data,
  output logic                      busy,
  output logic                      done
);

  localparam int HL = LANES / 2;
  localparam int WO = HL * DW;
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, EVEN, ODD, FIN} state_t;

  state_t              state_q, state_d;
  logic [4:0]          row_beats_q, row_beats_d;
  logic [5:0]          out_rows_q, out_rows_d;
  logic [4:0]          beat_cnt_q, beat_cnt_d;
  logic [5:0]          row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                s1_vld_q, s1_vld_d;
  logic [WO-1:0]       s1_h_q, s1_h_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WO-1:0]       wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [WO-1:0]       h_comb;
  logic [WO-1:0]       v_comb;
  logic [WO-1:0]       rb_rd_q;
  logic                rb_we;
  logic [BW-1:0]       beat_idx;
  logic                last_beat;
  logic [5:0]          row_cnt_inc;

  logic [WO-1:0]       row_buf [MAX_BEATS];

  assign beat_idx    = beat_cnt_q[BW-1:0];
  assign last_beat   = (beat_cnt_q == (row_beats_q - 5'd1));
  assign row_cnt_inc = row_cnt_q + 6'd1;

  // Per output lane: optional clamp, horizontal pair max, then vertical max against the stored even row.
  for (genvar gi = 0; gi < HL; gi++) begin : g_lane
    logic signed [DW-1:0] a, b, a_r, b_r, h, hq, rb;
    assign a = in_data[(2*gi)*DW +: DW];
    assign b = in_data[(2*gi+1)*DW +: DW];
`ifdef LENET_RELU_EN
    assign a_r = a[DW-1] ? '0 : a;
    assign b_r = b[DW-1] ? '0 : b;
`else
    assign a_r = a;
    assign b_r = b;
`endif
    assign h  = (a_r >= b_r) ? a_r : b_r;
    assign h_comb[gi*DW +: DW] = h;
    assign hq = s1_h_q[gi*DW +: DW];
    assign rb = rb_rd_q[gi*DW +: DW];
    assign v_comb[gi*DW +: DW] = (hq >= rb) ? hq : rb;
  end

  // Row buffer: no reset so it maps onto block RAM; read is registered alongside stage 1.
  always_ff @(posedge clk) begin
    if (rb_we) begin
      row_buf[beat_idx] <= h_comb;
    end
    rb_rd_q <= row_buf[beat_idx];
  end

  always_comb begin
    state_d     = state_q;
    row_beats_d = row_beats_q;
    out_rows_d  = out_rows_q;
    beat_cnt_d  = beat_cnt_q;
    row_cnt_d   = row_cnt_q;
    next_addr_d = next_addr_q;
    s1_vld_d    = 1'b0;
    s1_h_d      = h_comb;
    wr_en_d     = s1_vld_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rb_we       = 1'b0;

    if (s1_vld_q) begin
      wr_addr_d   = next_addr_q;
      wr_data_d   = v_comb;
      next_addr_d = next_addr_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          row_beats_d = cfg_row_beats;
          out_rows_d  = cfg_out_rows;
          beat_cnt_d  = '0;
          row_cnt_d   = '0;
          next_addr_d = cfg_base_addr;
          busy_d      = 1'b1;
          state_d     = EVEN;
        end
      end
      EVEN: begin
        if (in_vld) begin
          rb_we = 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = ODD;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end
      ODD: begin
        if (in_vld) begin
          s1_vld_d = 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            row_cnt_d  = row_cnt_inc;
            state_d    = (row_cnt_inc == out_rows_q) ? FIN : EVEN;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end
      FIN: begin
        // The final write is on the bus now; done follows it by one cycle.
        if (!s1_vld_q && wr_en_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_beats_q <= '0;
      out_rows_q  <= '0;
      beat_cnt_q  <= '0;
      row_cnt_q   <= '0;
      next_addr_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_h_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_beats_q <= row_beats_d;
      out_rows_q  <= out_rows_d;
      beat_cnt_q  <= beat_cnt_d;
      row_cnt_q   <= row_cnt_d;
      next_addr_q <= next_addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_h_q      <= s1_h_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
